// File: rtl/alu_pkg.sv
// Shared types and constants for the LEGv8-style execute-stage ALU.
package alu_pkg;

   localparam int unsigned ALU_WIDTH = 64;

   typedef enum logic [3:0] {
      ALU_AND   = 4'b0000,
      ALU_OR    = 4'b0001,
      ALU_ADD   = 4'b0010,
      ALU_SUB   = 4'b0110,
      ALU_PASSB = 4'b0111,
      ALU_NOR   = 4'b1100
   } alu_op_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor: sub_i inverts b_i and injects a carry-in of 1.
module alu_addsub #(
   parameter int unsigned Width = 64
) (
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic             sub_i,
   output logic [Width-1:0] sum_o,
   output logic             carry_o,
   output logic             ovf_o
);

   logic [Width-1:0] b_eff;
   logic [Width:0]   full_sum;

   always_comb begin
      b_eff    = sub_i ? ~b_i : b_i;
      full_sum = {1'b0, a_i} + {1'b0, b_eff} + {{Width{1'b0}}, sub_i};
      sum_o    = full_sum[Width-1:0];
      carry_o  = full_sum[Width];
      // Same-sign operands (after inversion) whose sum flips sign overflowed.
      ovf_o    = (a_i[Width-1] == b_eff[Width-1]) && (sum_o[Width-1] != a_i[Width-1]);
   end

endmodule

// File: rtl/alu.sv
// Registered LEGv8 ALU: operation mux and flag generation feeding one output register.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       SELECT,
   output logic [WIDTH-1:0] OUT,
   output logic             ZERO,
   output logic             NEG,
   output logic             CARRY,
   output logic             OVF
);

   logic [WIDTH-1:0] sum;
   logic             sum_carry;
   logic             sum_ovf;
   logic             is_sub;

   logic [WIDTH-1:0] out_d, out_q;
   logic             zero_d, zero_q;
   logic             neg_d, neg_q;
   logic             carry_d, carry_q;
   logic             ovf_d, ovf_q;

   assign is_sub = (SELECT == ALU_SUB);

   alu_addsub #(
      .Width (WIDTH)
   ) u_addsub (
      .a_i     (A),
      .b_i     (B),
      .sub_i   (is_sub),
      .sum_o   (sum),
      .carry_o (sum_carry),
      .ovf_o   (sum_ovf)
   );

   always_comb begin
      out_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (SELECT)
         ALU_AND:   out_d = A & B;
         ALU_OR:    out_d = A | B;
         ALU_ADD, ALU_SUB: begin
            out_d   = sum;
            carry_d = sum_carry;
            ovf_d   = sum_ovf;
         end
         ALU_PASSB: out_d = B;
         ALU_NOR:   out_d = ~(A | B);
         default:   out_d = '0;
      endcase
      zero_d = (out_d == '0);
      neg_d  = out_d[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         zero_q  <= 1'b1;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         out_q   <= out_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign OUT   = out_q;
   assign ZERO  = zero_q;
   assign NEG   = neg_q;
   assign CARRY = carry_q;
   assign OVF   = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; observed vector is {OUT, ZERO, NEG, CARRY, OVF}.
module tb_alu;

   localparam int unsigned W = 64;
   localparam logic [W-1:0] ONES = {W{1'b1}};

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   sel;
   logic [W-1:0] out;
   logic         zero, neg, carry, ovf;

   int passed = 0;
   int total  = 0;

   alu #(
      .WIDTH (W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .A      (a),
      .B      (b),
      .SELECT (sel),
      .OUT    (out),
      .ZERO   (zero),
      .NEG    (neg),
      .CARRY  (carry),
      .OVF    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W+3:0] obs();
      return {out, zero, neg, carry, ovf};
   endfunction

   // Drive one operation and return after the capturing edge (+1 time unit).
   task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [3:0] isel);
      a   = ia;
      b   = ib;
      sel = isel;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [W+3:0] exp_v;
      total++;
      exp_v = {{W{1'b0}}, 4'b1000};
      if (obs() !== exp_v) $display("FAIL reset_initial got=%h exp=%h", obs(), exp_v);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      issue(64'd5, 64'd9, 4'b0010);
      total++;
      exp_v = {64'd14, 4'b0000};
      if (obs() !== exp_v) $display("FAIL reset_preload got=%h exp=%h", obs(), exp_v);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      total++;
      exp_v = {{W{1'b0}}, 4'b1000};
      if (obs() !== exp_v) $display("FAIL reset_async got=%h exp=%h", obs(), exp_v);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (obs() !== exp_v) $display("FAIL reset_held got=%h exp=%h", obs(), exp_v);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      issue(64'd64, 64'd32, 4'b0010);
      total++;
      exp_v = {64'd96, 4'b0000};
      if (obs() !== exp_v) $display("FAIL reset_release got=%h exp=%h", obs(), exp_v);
      else passed++;
   endtask

   task automatic test_sweep();
      logic [3:0]   sels [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
      logic [W+3:0] exps [6] = '{
         {64'd0,                  4'b1000},
         {64'd96,                 4'b0000},
         {64'd96,                 4'b0000},
         {64'd32,                 4'b0010},
         {64'd32,                 4'b0000},
         {64'hFFFF_FFFF_FFFF_FF9F, 4'b0100}};
      for (int i = 0; i < 6; i++) begin
         issue(64'd64, 64'd32, sels[i]);
         total++;
         if (obs() !== exps[i]) $display("FAIL sweep_sel%b got=%h exp=%h", sels[i], obs(), exps[i]);
         else passed++;
      end
   endtask

   task automatic test_boundaries();
      logic [W-1:0] as   [4] = '{ONES, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000};
      logic [3:0]   sels [4] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110};
      logic [W+3:0] exps [4] = '{
         {64'd0,                  4'b1010},
         {64'h8000_0000_0000_0000, 4'b0101},
         {ONES,                   4'b0100},
         {64'h7FFF_FFFF_FFFF_FFFF, 4'b0011}};
      for (int i = 0; i < 4; i++) begin
         issue(as[i], 64'd1, sels[i]);
         total++;
         if (obs() !== exps[i]) $display("FAIL boundary_%0d got=%h exp=%h", i, obs(), exps[i]);
         else passed++;
      end
   endtask

   task automatic test_undefined();
      logic [3:0]   sels [3] = '{4'b0011, 4'b0101, 4'b1111};
      logic [W+3:0] exp_v;
      exp_v = {{W{1'b0}}, 4'b1000};
      for (int i = 0; i < 3; i++) begin
         issue(ONES, ONES, 4'b0111);
         issue(ONES, ONES, sels[i]);
         total++;
         if (obs() !== exp_v) $display("FAIL undef_sel%b got=%h exp=%h", sels[i], obs(), exp_v);
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]   sels [3] = '{4'b0010, 4'b0110, 4'b0000};
      logic [W-1:0] exps [3] = '{64'd13, 64'd7, 64'd2};
      logic [W-1:0] prev;
      issue(64'd0, 64'd0, 4'b0000);
      prev = 64'd0;
      for (int i = 0; i < 3; i++) begin
         a   = 64'd10;
         b   = 64'd3;
         sel = sels[i];
         #2;
         total++;
         if (out !== prev) $display("FAIL b2b_early_%0d got=%h exp=%h", i, out, prev);
         else passed++;
         @(posedge clk);
         #1;
         total++;
         if (out !== exps[i]) $display("FAIL b2b_out_%0d got=%h exp=%h", i, out, exps[i]);
         else passed++;
         prev = exps[i];
      end
   endtask

   task automatic test_glitch();
      issue(64'd10, 64'd3, 4'b0010);
      a = ONES; b = 64'd5; sel = 4'b1100;
      #1;
      a = 64'd1; b = ONES; sel = 4'b0110;
      #1;
      a = 64'd123; b = 64'd77; sel = 4'b0111;
      #1;
      total++;
      if (out !== 64'd13) $display("FAIL glitch_hold got=%h exp=%h", out, 64'd13);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (out !== 64'd77) $display("FAIL glitch_capture got=%h exp=%h", out, 64'd77);
      else passed++;
   endtask

   initial begin
      rst_n = 1'b0;
      a     = '0;
      b     = '0;
      sel   = 4'b0000;
      #12;
      test_reset();
      test_sweep();
      test_boundaries();
      test_undefined();
      test_back_to_back();
      test_glitch();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
